bcd_serial_add_ctrl: RTL and testbench

//  Sequencer that time-shares one single-digit BCD adder across an N-digit packed-BCD addition.

---
 rtl/bcd_pkg.sv | 16 +
 rtl/bcd_serial_add_ctrl_if.sv | 37 +++
 rtl/bcd_digit_adder.sv | 32 +++
 rtl/bcd_serial_add_ctrl.sv | 116 +++++++++++
 tb/tb_bcd_serial_add_ctrl.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/bcd_pkg.sv
// Shared definitions for the serial BCD adder slice.
// Contents: digit width, largest legal BCD digit, decimal correction
// constant, and the controller state encoding.
package bcd_pkg;

  localparam int         DIGIT_W  = 4;
  localparam logic [3:0] BCD_MAX  = 4'd9;
  localparam logic [3:0] BCD_CORR = 4'd6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/bcd_serial_add_ctrl_if.sv
// Handshake bundle between operand producer / result consumer and the
// serial BCD add controller.
// Signals:
//   in_valid/in_ready   operand pair handshake
//   in_a/in_b/in_cin    packed BCD operands (digit 0 in [3:0]) and carry-in
//   out_valid/out_ready result handshake
//   out_sum/out_cout    packed BCD sum and carry-out of the MSD
//   out_err             an input digit was not valid BCD
//   busy                controller is stepping through digits
// Modports: master = producer/consumer side, slave = controller side.
interface bcd_serial_add_ctrl_if #(
  parameter int NDIGITS = 4
);

  logic                   in_valid;
  logic                   in_ready;
  logic [4*NDIGITS-1:0]   in_a;
  logic [4*NDIGITS-1:0]   in_b;
  logic                   in_cin;
  logic                   out_valid;
  logic                   out_ready;
  logic [4*NDIGITS-1:0]   out_sum;
  logic                   out_cout;
  logic                   out_err;
  logic                   busy;

  modport master (
    output in_valid, in_a, in_b, in_cin, out_ready,
    input  in_ready, out_valid, out_sum, out_cout, out_err, busy
  );

  modport slave (
    input  in_valid, in_a, in_b, in_cin, out_ready,
    output in_ready, out_valid, out_sum, out_cout, out_err, busy
  );

endinterface

// File: rtl/bcd_digit_adder.sv
// Combinational single-digit decimal adder.
// Ports:
//   a, b  input BCD digits
//   cin   decimal carry-in
//   s     BCD result digit
//   cout  decimal carry-out
// Digits above 9 still produce a deterministic (meaningless) result.
module bcd_digit_adder
  import bcd_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);

  logic [4:0] raw;

  // Binary sum first; anything past 9 is pushed over the nibble boundary
  // by adding 6, and the bit that falls out is the decimal carry.
  always_comb begin
    raw  = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
    s    = raw[3:0];
    cout = 1'b0;
    if (raw > {1'b0, BCD_MAX}) begin
      s    = raw[3:0] + BCD_CORR;
      cout = 1'b1;
    end
  end

endmodule

// File: rtl/bcd_serial_add_ctrl.sv
// Sequencer that reuses one BCD digit adder across an NDIGITS-digit add,
// least significant digit first, rippling the decimal carry.
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous active-high reset
//   bus   slave side of bcd_serial_add_ctrl_if (operand and result
//         handshakes, sum, carry-out, error flag, busy)
module bcd_serial_add_ctrl
  import bcd_pkg::*;
#(
  parameter int NDIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  bcd_serial_add_ctrl_if.slave  bus
);

  localparam int CNT_W = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
  localparam int OP_W  = DIGIT_W * NDIGITS;

  state_e             state_q;
  logic [CNT_W-1:0]   idx_q;
  logic               carry_q;
  logic [OP_W-1:0]    op_a_q;
  logic [OP_W-1:0]    op_b_q;
  logic [OP_W-1:0]    sum_q;
  logic [OP_W-1:0]    sum_d;
  logic               cout_q;
  logic               err_q;
  logic               valid_q;
  logic               busy_q;

  logic [3:0]         a_dig;
  logic [3:0]         b_dig;
  logic [3:0]         dig_s;
  logic               dig_cout;

  assign a_dig = op_a_q[idx_q*DIGIT_W +: DIGIT_W];
  assign b_dig = op_b_q[idx_q*DIGIT_W +: DIGIT_W];

  bcd_digit_adder u_digit (
    .a    (a_dig),
    .b    (b_dig),
    .cin  (carry_q),
    .s    (dig_s),
    .cout (dig_cout)
  );

  // Sum register with the current digit slot replaced by the adder output.
  always_comb begin
    sum_d = sum_q;
    sum_d[idx_q*DIGIT_W +: DIGIT_W] = dig_s;
  end

  // Controller FSM and datapath registers. Results stay in their registers
  // after handoff and are only cleared when the next operand pair arrives.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      op_a_q  <= '0;
      op_b_q  <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            op_a_q  <= bus.in_a;
            op_b_q  <= bus.in_b;
            carry_q <= bus.in_cin;
            idx_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= ADD;
          end
        end
        ADD: begin
          sum_q   <= sum_d;
          carry_q <= dig_cout;
          err_q   <= err_q | (a_dig > BCD_MAX) | (b_dig > BCD_MAX);
          if (idx_q == CNT_W'(NDIGITS - 1)) begin
            cout_q  <= dig_cout;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b1;
            state_q <= DONE;
          end else begin
            idx_q <= idx_q + CNT_W'(1);
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            valid_q <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = valid_q;
  assign bus.out_sum   = sum_q;
  assign bus.out_cout  = cout_q;
  assign bus.out_err   = err_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_bcd_serial_add_ctrl.sv
// Self-checking bench for bcd_serial_add_ctrl (NDIGITS = 4).
// Expected results come from a decimal model: operands are converted to
// integers, added, and converted back to packed BCD.
module tb_bcd_serial_add_ctrl;

  localparam int N = 4;
  localparam int W = 4 * N;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  bcd_serial_add_ctrl_if #(.NDIGITS(N)) bus ();

  bcd_serial_add_ctrl #(.NDIGITS(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model helpers
  function automatic longint bcd2int(input logic [W-1:0] v);
    longint r = 0;
    for (int i = N - 1; i >= 0; i--) r = r * 10 + longint'(v[i*4 +: 4]);
    return r;
  endfunction

  function automatic logic [W-1:0] int2bcd(input longint v);
    logic [W-1:0] r = '0;
    longint t = v;
    for (int i = 0; i < N; i++) begin
      r[i*4 +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic logic anyBad(input logic [W-1:0] v);
    for (int i = 0; i < N; i++) if (v[i*4 +: 4] > 4'd9) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [W-1:0] randBcd();
    logic [W-1:0] r = '0;
    for (int i = 0; i < N; i++) r[i*4 +: 4] = 4'($urandom_range(0, 9));
    return r;
  endfunction

  function automatic longint limitVal();
    longint l = 1;
    for (int i = 0; i < N; i++) l = l * 10;
    return l;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // All tasks start and end just after a falling edge.
  task automatic waitReady();
    int n = 0;
    while (!bus.in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) checkOutput("in_ready_timeout", 32'(bus.in_ready), 32'd1);
  endtask

  task automatic waitValid(output int lat);
    lat = 1;
    while (!bus.out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic cin, output int lat);
    waitReady();
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_cin   = cin;
    bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_a     = W'($urandom);
    bus.in_b     = W'($urandom);
    bus.in_cin   = 1'($urandom);
    waitValid(lat);
  endtask

  task automatic consume();
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    checkOutput("valid_drop", 32'(bus.out_valid), 32'd0);
    checkOutput("ready_back", 32'(bus.in_ready), 32'd1);
  endtask

  task automatic runOp(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic cin, input bit checkSum);
    longint total;
    int lat;
    total = bcd2int(a) + bcd2int(b) + longint'(cin);
    applyStimulus(a, b, cin, lat);
    checkOutput({tag, "_lat"}, 32'(lat), 32'(N + 1));
    checkOutput({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
    if (checkSum) begin
      checkOutput({tag, "_sum"}, 32'(bus.out_sum), 32'(int2bcd(total % limitVal())));
      checkOutput({tag, "_cout"}, 32'(bus.out_cout), 32'(total >= limitVal()));
    end
    checkOutput({tag, "_err"}, 32'(bus.out_err), 32'(anyBad(a) | anyBad(b)));
    consume();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat;
    int n;
    int accCyc;
    int prevAcc;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic cin;
    longint total;

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_cin    = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state
    checkOutput("rst_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("rst_sum", 32'(bus.out_sum), 32'd0);
    checkOutput("rst_cout", 32'(bus.out_cout), 32'd0);
    checkOutput("rst_err", 32'(bus.out_err), 32'd0);
    checkOutput("rst_busy", 32'(bus.busy), 32'd0);
    checkOutput("rst_ready", 32'(bus.in_ready), 32'd1);

    // Directed cases
    runOp("d99", 16'h0099, 16'h0099, 1'b0, 1'b1);
    runOp("d9999", 16'h9999, 16'h0001, 1'b0, 1'b1);
    runOp("d4999", 16'h4999, 16'h5000, 1'b1, 1'b1);
    runOp("derr", 16'h00A0, 16'h0001, 1'b0, 1'b0);
    runOp("dafter", 16'h0001, 16'h0001, 1'b0, 1'b1);

    // Back-pressure: result must hold while new operands wait
    applyStimulus(16'h0123, 16'h0456, 1'b0, lat);
    checkOutput("bp_valid0", 32'(bus.out_valid), 32'd1);
    bus.in_a     = 16'h0111;
    bus.in_b     = 16'h0222;
    bus.in_cin   = 1'b0;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput("bp_ready", 32'(bus.in_ready), 32'd0);
      checkOutput("bp_hold", {15'd0, bus.out_valid, bus.out_sum}, {15'd0, 1'b1, 16'h0579});
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    checkOutput("bp_release_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    checkOutput("bp_next_busy", 32'(bus.busy), 32'd1);
    waitValid(lat);
    checkOutput("bp_next_sum", 32'(bus.out_sum), 32'h0333);
    consume();

    // Reset during the second ADD cycle abandons the operation
    waitReady();
    bus.in_a     = 16'h5555;
    bus.in_b     = 16'h4444;
    bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("mrst_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("mrst_busy", 32'(bus.busy), 32'd0);
    checkOutput("mrst_sum", 32'(bus.out_sum), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("mrst_ready", 32'(bus.in_ready), 32'd1);
    checkOutput("mrst_valid2", 32'(bus.out_valid), 32'd0);
    runOp("post_rst", 16'h1234, 16'h4321, 1'b0, 1'b1);

    // Back-to-back with both handshakes held high
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    prevAcc = 0;
    for (int k = 0; k < 5; k++) begin
      a   = randBcd();
      b   = randBcd();
      cin = 1'($urandom);
      bus.in_a   = a;
      bus.in_b   = b;
      bus.in_cin = cin;
      n = 0;
      while (!bus.in_ready && n < 100) begin
        @(negedge clk);
        n++;
      end
      if (!bus.in_ready) checkOutput("b2b_ready_timeout", 32'(bus.in_ready), 32'd1);
      accCyc = cyc;
      if (k > 0) checkOutput("b2b_spacing", 32'(accCyc - prevAcc), 32'(N + 2));
      prevAcc = accCyc;
      @(posedge clk);
      @(negedge clk);
      bus.in_a = W'($urandom);
      bus.in_b = W'($urandom);
      waitValid(lat);
      total = bcd2int(a) + bcd2int(b) + longint'(cin);
      checkOutput("b2b_sum", 32'(bus.out_sum), 32'(int2bcd(total % limitVal())));
      checkOutput("b2b_cout", 32'(bus.out_cout), 32'(total >= limitVal()));
    end
    bus.in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    checkOutput("b2b_idle", 32'(bus.in_ready), 32'd1);

    // Random valid-BCD sweep
    for (int k = 0; k < 15; k++) begin
      runOp("rand", randBcd(), randBcd(), 1'($urandom), 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
